// File: rtl/morse_encoder_pkg.sv
// morse_encoder_pkg: state encodings, code format and unit multipliers for the Morse keyer
package morse_encoder_pkg;
  localparam int unsigned LEN_W = 3;
  localparam int unsigned PAT_W = 5;
  localparam int unsigned DOT_U = 1;
  localparam int unsigned DASH_U = 3;
  localparam int unsigned GAP_U = 1;
  localparam int unsigned CHAR_GAP_U = 3;
  localparam int unsigned WORD_GAP_U = 7;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  typedef enum logic [2:0] {IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP} state_e;
  typedef struct packed {
    logic             valid;
    logic             is_space;
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pat;
  } code_t;
  function automatic code_t mk(input logic [LEN_W-1:0] len, input logic [PAT_W-1:0] pat);
    return '{valid: 1'b1, is_space: 1'b0, len: len, pat: pat};
  endfunction
endpackage

// File: rtl/morse_encoder_lut.sv
// morse_encoder_lut: ASCII to Morse code lookup, lower case folded onto upper case
module morse_encoder_lut
  import morse_encoder_pkg::*;
(
  input  logic [7:0] ascii_i,
  output code_t      code_o
);
  logic [7:0] up;
  always_comb begin
    up = (ascii_i >= 8'h61 && ascii_i <= 8'h7a) ? ascii_i - 8'h20 : ascii_i;
    code_o = '0;
    case (up)
      ASCII_SPACE: code_o = '{valid: 1'b1, is_space: 1'b1, len: '0, pat: '0};
      // pattern occupies the low len bits, first element in the highest of them
      8'h41: code_o = mk(3'd2, 5'b00001);
      8'h42: code_o = mk(3'd4, 5'b01000);
      8'h43: code_o = mk(3'd4, 5'b01010);
      8'h44: code_o = mk(3'd3, 5'b00100);
      8'h45: code_o = mk(3'd1, 5'b00000);
      8'h46: code_o = mk(3'd4, 5'b00010);
      8'h47: code_o = mk(3'd3, 5'b00110);
      8'h48: code_o = mk(3'd4, 5'b00000);
      8'h49: code_o = mk(3'd2, 5'b00000);
      8'h4a: code_o = mk(3'd4, 5'b00111);
      8'h4b: code_o = mk(3'd3, 5'b00101);
      8'h4c: code_o = mk(3'd4, 5'b00100);
      8'h4d: code_o = mk(3'd2, 5'b00011);
      8'h4e: code_o = mk(3'd2, 5'b00010);
      8'h4f: code_o = mk(3'd3, 5'b00111);
      8'h50: code_o = mk(3'd4, 5'b00110);
      8'h51: code_o = mk(3'd4, 5'b01101);
      8'h52: code_o = mk(3'd3, 5'b00010);
      8'h53: code_o = mk(3'd3, 5'b00000);
      8'h54: code_o = mk(3'd1, 5'b00001);
      8'h55: code_o = mk(3'd3, 5'b00001);
      8'h56: code_o = mk(3'd4, 5'b00001);
      8'h57: code_o = mk(3'd3, 5'b00011);
      8'h58: code_o = mk(3'd4, 5'b01001);
      8'h59: code_o = mk(3'd4, 5'b01011);
      8'h5a: code_o = mk(3'd4, 5'b01100);
      8'h30: code_o = mk(3'd5, 5'b11111);
      8'h31: code_o = mk(3'd5, 5'b01111);
      8'h32: code_o = mk(3'd5, 5'b00111);
      8'h33: code_o = mk(3'd5, 5'b00011);
      8'h34: code_o = mk(3'd5, 5'b00001);
      8'h35: code_o = mk(3'd5, 5'b00000);
      8'h36: code_o = mk(3'd5, 5'b10000);
      8'h37: code_o = mk(3'd5, 5'b11000);
      8'h38: code_o = mk(3'd5, 5'b11100);
      8'h39: code_o = mk(3'd5, 5'b11110);
      default: code_o = '0;
    endcase
  end
endmodule

// File: rtl/morse_encoder.sv
// morse_encoder: keys one accepted ASCII character at a time out as Morse with unit timing
module morse_encoder
  import morse_encoder_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 6_000_000,
  parameter int unsigned CNT_W = $clog2(UNIT_CYCLES * 7 + 1)
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       morse_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       invalid_o
);
  if (UNIT_CYCLES < 2 || ((64'(UNIT_CYCLES) * 64'd7) >> CNT_W) != 64'd0) begin : g_chk
    $error("UNIT_CYCLES must be >= 2 and 7*UNIT_CYCLES must fit in CNT_W bits");
  end
  function automatic logic [CNT_W-1:0] ld(input int unsigned u);
    return CNT_W'(u * UNIT_CYCLES - 32'd1);
  endfunction
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             done_q, done_d, invalid_q, invalid_d;
  code_t            code;
  logic             last;
  morse_encoder_lut u_lut (.ascii_i(data_i), .code_o(code));
  assign last = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE) ? '0 : cnt_q - 1'b1;
    idx_d = idx_q;
    pat_d = pat_q;
    done_d = 1'b0;
    invalid_d = 1'b0;
    case (state_q)
      IDLE: if (valid_i) begin
        invalid_d = !code.valid;
        if (code.valid && code.is_space) begin
          state_d = WORD_GAP;
          cnt_d = ld(WORD_GAP_U);
        end else if (code.valid) begin
          state_d = MARK;
          pat_d = code.pat;
          idx_d = code.len - 3'd1;
          cnt_d = ld(code.pat[code.len - 3'd1] ? DASH_U : DOT_U);
        end
      end
      MARK: if (last) begin
        state_d = (idx_q == '0) ? CHAR_GAP : ELEM_GAP;
        cnt_d = ld((idx_q == '0) ? CHAR_GAP_U : GAP_U);
        idx_d = (idx_q == '0) ? idx_q : idx_q - 3'd1;
      end
      ELEM_GAP: if (last) begin
        state_d = MARK;
        cnt_d = ld(pat_q[idx_q] ? DASH_U : DOT_U);
      end
      CHAR_GAP, WORD_GAP: if (last) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      pat_q <= '0;
      done_q <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pat_q <= pat_d;
      done_q <= done_d;
      invalid_q <= invalid_d;
    end
  end
  assign ready_o = state_q == IDLE;
  assign busy_o = !ready_o;
  assign morse_o = state_q == MARK;
  assign done_o = done_q;
  assign invalid_o = invalid_q;
endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: scoreboard bench, expected per-cycle waveform queued from a dot/dash table
module tb_morse_encoder;
  localparam int unsigned U = 4;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic valid_i = 1'b0;
  logic ready_o, morse_o, busy_o, done_o, invalid_o;
  typedef struct packed {logic m; logic b; logic d;} exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  string tbl[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                     "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                     "..-", "...-", ".--", "-..-", "-.--", "--..",
                     "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                     "---..", "----."};

  morse_encoder #(.UNIT_CYCLES(U)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .morse_o(morse_o), .busy_o(busy_o), .done_o(done_o),
    .invalid_o(invalid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic string code_of(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    if (u >= 8'h41 && u <= 8'h5a) return tbl[int'(u) - 65];
    if (u >= 8'h30 && u <= 8'h39) return tbl[26 + int'(u) - 48];
    return "";
  endfunction

  task automatic push_char(input logic [7:0] c);
    string s;
    if (c == 8'h20) begin
      repeat (7 * U) q.push_back('{1'b0, 1'b1, 1'b0});
    end else begin
      s = code_of(c);
      for (int i = 0; i < s.len(); i++) begin
        repeat ((s[i] == 8'h2d) ? 3 * U : U) q.push_back('{1'b1, 1'b1, 1'b0});
        repeat ((i == s.len() - 1) ? 3 * U : U) q.push_back('{1'b0, 1'b1, 1'b0});
      end
    end
    q.push_back('{1'b0, 1'b0, 1'b1});
  endtask

  // valid_i stays high throughout; a decoy byte sits on data_i while busy
  task automatic play(input string str);
    int k;
    int cyc;
    bit fresh;
    exp_t e;
    @(negedge clk_i);
    valid_i = 1'b1;
    data_i = str[0];
    push_char(str[0]);
    k = 1;
    cyc = 0;
    fresh = 1'b1;
    while (q.size() > 0) begin
      @(negedge clk_i);
      cyc++;
      e = q.pop_front();
      n_cmp++;
      if ({morse_o, busy_o, done_o, ready_o, invalid_o} !== {e.m, e.b, e.d, ~e.b, 1'b0}) begin
        n_bad++;
        $display("FAIL play(\"%s\") char %0d cycle %0d: m/b/d/r/i got %b%b%b%b%b expected %b%b%b%b0",
                 str, k - 1, cyc, morse_o, busy_o, done_o, ready_o, invalid_o, e.m, e.b, e.d, ~e.b);
      end
      if (fresh && !e.d) data_i = 8'h54;
      fresh = 1'b0;
      if (e.d) begin
        cyc = 0;
        if (k < str.len()) begin
          data_i = str[k];
          push_char(str[k]);
          k++;
          fresh = 1'b1;
        end else begin
          valid_i = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({morse_o, busy_o, ready_o, done_o, invalid_o} !== 5'b00100) begin
      n_bad++;
      $display("FAIL reset_state: m/b/r/d/i got %b%b%b%b%b expected 00100",
               morse_o, busy_o, ready_o, done_o, invalid_o);
    end
    reset_ni = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if ({morse_o, busy_o, ready_o} !== 3'b001) begin
      n_bad++;
      $display("FAIL after_release: m/b/r got %b%b%b expected 001", morse_o, busy_o, ready_o);
    end
  endtask

  task automatic test_letters;
    play("E");
    play("A");
    play("a");
    play("Kz");
  endtask

  task automatic test_digits;
    play("0");
    play("59");
  endtask

  task automatic test_space;
    play(" ");
  endtask

  task automatic test_invalid;
    @(negedge clk_i);
    valid_i = 1'b1;
    data_i = 8'h23;
    @(negedge clk_i);
    valid_i = 1'b0;
    n_cmp++;
    if ({invalid_o, ready_o, morse_o, busy_o, done_o} !== 5'b11000) begin
      n_bad++;
      $display("FAIL invalid_pulse: i/r/m/b/d got %b%b%b%b%b expected 11000",
               invalid_o, ready_o, morse_o, busy_o, done_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({invalid_o, ready_o, morse_o, busy_o, done_o} !== 5'b01000) begin
        n_bad++;
        $display("FAIL invalid_after[%0d]: i/r/m/b/d got %b%b%b%b%b expected 01000",
                 i, invalid_o, ready_o, morse_o, busy_o, done_o);
      end
    end
  endtask

  task automatic test_back_to_back;
    play("SOS");
  endtask

  task automatic test_reset_mid;
    @(negedge clk_i);
    valid_i = 1'b1;
    data_i = 8'h54;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    n_cmp++;
    if (morse_o !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_dash: morse_o got %b expected 1", morse_o);
    end
    #2 reset_ni = 1'b0;
    #1;
    n_cmp++;
    if ({morse_o, busy_o, ready_o} !== 3'b001) begin
      n_bad++;
      $display("FAIL async_abort: m/b/r got %b%b%b expected 001", morse_o, busy_o, ready_o);
    end
    @(negedge clk_i);
    reset_ni = 1'b1;
    play("E");
  endtask

  initial begin
    test_reset;
    test_letters;
    test_digits;
    test_space;
    test_invalid;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
